// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Build option PC_COMPRESSED_EN relaxes target alignment to 2 bytes.
package pc_pkg;

  typedef enum logic [2:0] {
    MODE_SEQ    = 3'd0,
    MODE_BRANCH = 3'd1,
    MODE_JAL    = 3'd2,
    MODE_JALR   = 3'd3,
    MODE_ABS    = 3'd4
  } pc_mode_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

`ifdef PC_COMPRESSED_EN
  localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target and misalignment detection.
// Alignment rule follows ALIGN_MASK (PC_COMPRESSED_EN selects 2-byte alignment).
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_SHIFT = 1
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      mode,
  input  logic            taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic            take,
  output logic            misaligned
);

  logic signed [XLEN-1:0] imm_s;
  logic        [XLEN-1:0] imm_sh;
  logic        [XLEN-1:0] jalr_sum;

  assign imm_s    = imm;
  assign imm_sh   = imm_s <<< IMM_SHIFT;
  assign jalr_sum = rs1 + imm;

  // A not-taken branch falls back to the sequential path, so it does not redirect.
  always_comb begin
    target = '0;
    take   = 1'b0;
    case (pc_mode_e'(mode))
      MODE_BRANCH: begin
        take   = taken;
        target = pc + imm_sh;
      end
      MODE_JAL: begin
        take   = 1'b1;
        target = pc + imm_sh;
      end
      MODE_JALR: begin
        take   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      MODE_ABS: begin
        take   = 1'b1;
        target = imm_sh;
      end
      default: ;
    endcase
  end

  assign misaligned = |(target[1:0] & ALIGN_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch handshake, redirects, halt/resume, misaligned-target trap.
// Build option PC_COMPRESSED_EN adds seq_step2 (2-byte sequential step).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              IMM_SHIFT    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [2:0]      redirect_mode,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic [XLEN-1:0] redirect_rs1,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
`ifdef PC_COMPRESSED_EN
  input  logic            seq_step2,
`endif
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_valid,
  output logic [XLEN-1:0] link_addr,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] target;
  logic            take;
  logic            misaligned;
  logic            handshake;

`ifdef PC_COMPRESSED_EN
  assign step = seq_step2 ? XLEN'(2) : XLEN'(4);
`else
  assign step = XLEN'(4);
`endif

  pc_target_calc #(
    .XLEN      (XLEN),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_target (
    .pc         (pc_q),
    .mode       (redirect_mode),
    .taken      (branch_taken),
    .imm        (redirect_imm),
    .rs1        (redirect_rs1),
    .target     (target),
    .take       (take),
    .misaligned (misaligned)
  );

  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign handshake   = fetch_valid && fetch_ready;

  // A redirect overrides the pending fetch whether or not it was accepted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    trap_d  = 1'b0;
    if (enable) begin
      case (state_q)
        BOOT: state_d = halt_req ? HALT : RUN;
        RUN: begin
          if (redirect_valid && take) begin
            if (misaligned) begin
              pc_d   = TRAP_VECTOR;
              trap_d = 1'b1;
              tval_d = target;
            end else begin
              pc_d = target;
            end
          end else if (handshake) begin
            pc_d = pc_q + step;
          end
          if (halt_req) state_d = HALT;
        end
        HALT: if (resume && !halt_req) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      tval_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      trap_q  <= trap_d;
    end
  end

  assign pc_out     = pc_q;
  assign link_addr  = pc_q + step;
  assign trap_valid = trap_q;
  assign trap_tval  = tval_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        redirect_valid;
  logic [2:0]  redirect_mode;
  logic        branch_taken;
  logic [31:0] redirect_imm;
  logic [31:0] redirect_rs1;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic [31:0] link_addr;
  logic        trap_valid;
  logic [31:0] trap_tval;
  logic        halted;
`ifdef PC_COMPRESSED_EN
  logic        seq_step2 = 1'b0;
  localparam logic [31:0] AMASK = 32'h1;
`else
  localparam logic [31:0] AMASK = 32'h3;
`endif

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_mode  (redirect_mode),
    .branch_taken   (branch_taken),
    .redirect_imm   (redirect_imm),
    .redirect_rs1   (redirect_rs1),
    .halt_req       (halt_req),
    .resume         (resume),
    .fetch_ready    (fetch_ready),
`ifdef PC_COMPRESSED_EN
    .seq_step2      (seq_step2),
`endif
    .pc_out         (pc_out),
    .fetch_valid    (fetch_valid),
    .link_addr      (link_addr),
    .trap_valid     (trap_valid),
    .trap_tval      (trap_tval),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Reference model: booting/halted flags, pc, trap state.
  bit          m_boot, m_halt, m_trap;
  logic [31:0] m_pc, m_tval;

  function automatic void model_reset();
    m_boot = 1; m_halt = 0; m_trap = 0; m_pc = 32'h0; m_tval = 32'h0;
  endfunction

  function automatic void model_step();
    logic [31:0] tgt;
    bit          jump;
    bit          nt;
    tgt  = 32'h0;
    jump = 0;
    nt   = 0;
    case (redirect_mode)
      3'd1: begin jump = branch_taken; tgt = m_pc + (redirect_imm << 1); end
      3'd2: begin jump = 1; tgt = m_pc + (redirect_imm << 1); end
      3'd3: begin jump = 1; tgt = (redirect_rs1 + redirect_imm) & 32'hFFFF_FFFE; end
      3'd4: begin jump = 1; tgt = redirect_imm << 1; end
      default: jump = 0;
    endcase
    if (enable) begin
      if (m_boot) begin
        m_boot = 0;
        m_halt = halt_req;
      end else if (m_halt) begin
        if (resume && !halt_req) m_halt = 0;
      end else begin
        if (redirect_valid && jump) begin
          if ((tgt & AMASK) != 0) begin
            m_pc = 32'h100; nt = 1; m_tval = tgt;
          end else begin
            m_pc = tgt;
          end
        end else if (fetch_ready) begin
          m_pc = m_pc + 4;
        end
        if (halt_req) m_halt = 1;
      end
    end
    m_trap = nt;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input bit v, input logic [2:0] mode, input bit tk,
                           input logic [31:0] imm, input logic [31:0] rs1);
    redirect_valid = v; redirect_mode = mode; branch_taken = tk;
    redirect_imm = imm; redirect_rs1 = rs1;
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 1; halt_req = 0; resume = 0; fetch_ready = 1;
    set_redir(0, 3'd0, 0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    n_vec++; if ({fetch_valid, trap_valid, halted} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {fetch_valid, trap_valid, halted}); end
    n_vec++; if (trap_tval !== 32'h0) begin n_err++; $display("FAIL reset_tval got %h exp 0", trap_tval); end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL boot_fv got %b exp 0", fetch_valid); end
    tick();
    n_vec++; if (pc_out !== 32'h0 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL boot_pc0 got %h/%b exp 0/1", pc_out, fetch_valid); end
    tick();
    n_vec++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL seq_pc4 got %h exp 4", pc_out); end
    n_vec++; if (link_addr !== 32'h8) begin n_err++; $display("FAIL link_addr got %h exp 8", link_addr); end
    tick();
    n_vec++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL seq_pc8 got %h exp 8", pc_out); end
  endtask

  task automatic test_backpressure();
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (pc_out !== 32'h8 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got %h/%b exp 8/1", i, pc_out, fetch_valid); end
    end
    fetch_ready = 1;
    tick();
    n_vec++; if (pc_out !== 32'hC) begin n_err++; $display("FAIL bp_release got %h exp c", pc_out); end
  endtask

  task automatic test_branch();
    tick();
    n_vec++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL br_setup got %h exp 10", pc_out); end
    set_redir(1, 3'd1, 1, 32'd8, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h20) begin n_err++; $display("FAIL br_taken got %h exp 20", pc_out); end
    set_redir(1, 3'd4, 0, 32'd8, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL abs_10 got %h exp 10", pc_out); end
    set_redir(1, 3'd1, 0, 32'd8, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h14) begin n_err++; $display("FAIL br_not_taken got %h exp 14", pc_out); end
    set_redir(1, 3'd4, 0, 32'd8, 32'h0); tick();
    set_redir(1, 3'd3, 0, 32'd2, 32'h1001); tick();
`ifdef PC_COMPRESSED_EN
    n_vec++; if (pc_out !== 32'h1002 || trap_valid !== 1'b0) begin n_err++; $display("FAIL jalr got %h/%b exp 1002/0", pc_out, trap_valid); end
`else
    n_vec++; if (pc_out !== 32'h100 || trap_valid !== 1'b1 || trap_tval !== 32'h1002) begin n_err++; $display("FAIL jalr_trap got %h/%b/%h exp 100/1/1002", pc_out, trap_valid, trap_tval); end
`endif
  endtask

  task automatic test_misaligned();
    set_redir(1, 3'd4, 0, 32'h20, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL mis_setup got %h exp 40", pc_out); end
    set_redir(1, 3'd2, 0, 32'd1, 32'h0); tick();
`ifdef PC_COMPRESSED_EN
    n_vec++; if (pc_out !== 32'h42 || trap_valid !== 1'b0) begin n_err++; $display("FAIL jal_c got %h/%b exp 42/0", pc_out, trap_valid); end
`else
    n_vec++; if (pc_out !== 32'h100 || trap_valid !== 1'b1 || trap_tval !== 32'h42) begin n_err++; $display("FAIL jal_trap got %h/%b/%h exp 100/1/42", pc_out, trap_valid, trap_tval); end
    set_redir(0, 3'd0, 0, 32'h0, 32'h0); tick();
    n_vec++; if (trap_valid !== 1'b0 || trap_tval !== 32'h42 || pc_out !== 32'h104) begin n_err++; $display("FAIL trap_pulse got %b/%h/%h exp 0/42/104", trap_valid, trap_tval, pc_out); end
`endif
  endtask

  task automatic test_halt();
    halt_req = 1; set_redir(1, 3'd4, 0, 32'h80, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h100 || halted !== 1'b1 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL halt_redir got %h/%b/%b exp 100/1/0", pc_out, halted, fetch_valid); end
    halt_req = 0; set_redir(1, 3'd2, 0, 32'd4, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h100 || halted !== 1'b1) begin n_err++; $display("FAIL halt_ignore got %h/%b exp 100/1", pc_out, halted); end
    halt_req = 1; resume = 1; tick();
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_wins got %b exp 1", halted); end
    halt_req = 0; set_redir(0, 3'd0, 0, 32'h0, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h100 || fetch_valid !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL resume got %h/%b/%b exp 100/1/0", pc_out, fetch_valid, halted); end
    resume = 0;
    enable = 0; set_redir(1, 3'd4, 0, 32'h40, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h100 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL enable_freeze got %h/%b exp 100/1", pc_out, fetch_valid); end
    enable = 1; set_redir(0, 3'd0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_async_reset();
    set_redir(1, 3'd4, 0, 32'h12, 32'h0); tick();
    n_vec++; if (pc_out !== 32'h24) begin n_err++; $display("FAIL ar_setup got %h exp 24", pc_out); end
    set_redir(1, 3'd2, 0, 32'd1, 32'h0);
    #3 reset_n = 0;
    #1;
    n_vec++; if (pc_out !== 32'h0 || fetch_valid !== 1'b0 || trap_valid !== 1'b0) begin n_err++; $display("FAIL ar_immediate got %h/%b/%b exp 0/0/0", pc_out, fetch_valid, trap_valid); end
    @(posedge clk); #1;
    n_vec++; if (trap_valid !== 1'b0 || trap_tval !== 32'h0) begin n_err++; $display("FAIL ar_no_trap got %b/%h exp 0/0", trap_valid, trap_tval); end
    set_redir(0, 3'd0, 0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      enable         = ($urandom % 8) != 0;
      redirect_valid = ($urandom % 3) == 0;
      redirect_mode  = 3'($urandom % 5);
      branch_taken   = 1'($urandom);
      redirect_imm   = (($urandom % 6) == 0) ? $urandom : (32'($urandom_range(0, 511)) << 1);
      redirect_rs1   = (($urandom % 6) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      halt_req       = ($urandom % 20) == 0;
      resume         = ($urandom % 4) == 0;
      fetch_ready    = ($urandom % 4) != 0;
      tick();
      n_vec++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, pc_out, m_pc); end
      n_vec++; if (fetch_valid !== (!m_boot && !m_halt)) begin n_err++; $display("FAIL rnd_fv c=%0d got %b exp %b", c, fetch_valid, !m_boot && !m_halt); end
      n_vec++; if (halted !== m_halt) begin n_err++; $display("FAIL rnd_halted c=%0d got %b exp %b", c, halted, m_halt); end
      n_vec++; if (trap_valid !== m_trap) begin n_err++; $display("FAIL rnd_trap c=%0d got %b exp %b", c, trap_valid, m_trap); end
      n_vec++; if (trap_tval !== m_tval) begin n_err++; $display("FAIL rnd_tval c=%0d got %h exp %h", c, trap_tval, m_tval); end
      n_vec++; if (link_addr !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_link c=%0d got %h exp %h", c, link_addr, m_pc + 32'd4); end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_branch();
    test_misaligned();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
